auto_rsp_engine: RTL and testbench
==================================

Name: auto_rsp_engine

Overview:
- Consumer of the request channel and producer of the response channel for the auto_intf link.
- Accepts credit-flow-controlled 64-bit requests into a local FIFO.
- Executes each request in order against a small register file.
- Issues 2-bit-command / 64-bit-data responses, gated by downstream response credits.
- Returns one request credit per request it retires.

Parameters:
- DEPTH, 4: request FIFO entries; equals the initial credit count held by the requester.
- RSP_CREDITS, 4: initial and maximum downstream response credits.
- NREGS, 16: register file entries, each 48 bits; the address is req_dat[59:56].

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_val  input  1  request beat valid; sender may assert only while holding a credit
- req_dat  input  64  request beat: [63:62] op, [59:56] addr, [47:0] wdata
- req_credit  output  1  one-cycle pulse, one credit returned to the requester
- rsp_cmd  output  2  0 IDLE, 1 ACK, 2 DATA, 3 ERR; nonzero means a response beat
- rsp_data  output  64  response payload, valid when rsp_cmd != 0
- rsp_credit  input  1  one-cycle pulse, one response credit returned by the consumer
- ovf_err  output  1  sticky: req_val arrived while the FIFO was full
- credit_err  output  1  sticky: rsp_credit arrived with the counter already at RSP_CREDITS
- rsp_credits_avail  output  $clog2(RSP_CREDITS+1)  current response credit count

Behaviour:
- Reset, asynchronous, rst_n low:
  - FIFO emptied; register file cleared to 0.
  - rsp_cmd=0, rsp_data=0, req_credit=0, ovf_err=0, credit_err=0.
  - rsp_credits_avail=RSP_CREDITS.
  - Reset mid-operation discards all queued requests. Requester and consumer must also reset their credit counts.
- Accept: req_val=1 with the FIFO not full writes req_dat at the edge.
- Overflow: req_val=1 with the FIFO full drops the beat and sets ovf_err. FIFO contents are unchanged.
- Pop condition, evaluated each cycle on the FIFO head. The head is popped when the FIFO is not empty and either:
  - op=00 (NOP), or
  - rsp_credits_avail>0.
- Execute on pop, with outputs registered the next cycle:
  - op=00 NOP: no response (rsp_cmd=0); no response credit consumed.
  - op=01 WRITE: reg[addr] <= wdata. rsp_cmd=ACK, rsp_data={60'b0, addr}.
  - op=10 READ: rsp_cmd=DATA, rsp_data={16'b0, reg[addr]}.
  - op=11: rsp_cmd=ERR, rsp_data=req_dat echoed.
  - In all four cases req_credit pulses for exactly 1 cycle, in the same cycle as the response beat.
- Latency and throughput:
  - A request accepted at edge N can pop at N+1; its response and credit appear after edge N+2.
  - One pop per cycle maximum; full throughput with credits available.
  - Accept and pop in the same cycle are allowed, including when the FIFO is full (pop frees the slot first).
- Ordering:
  - Strictly in order.
  - The register write takes effect at the pop edge, so a READ popped the next cycle returns the new value (read-after-write).
- Response credit counter:
  - Decrements on each non-NOP pop; increments on rsp_credit.
  - A simultaneous pop and return leaves it unchanged.
  - A return at RSP_CREDITS saturates and sets credit_err.
  - At 0, the head stalls (unless it is a NOP) until a credit returns.
- rsp_cmd returns to 0 in any cycle without a pop.

Decomposition:
- Package auto_rsp_pkg:
  - op_e {OP_NOP, OP_WR, OP_RD, OP_BAD}
  - rsp_cmd_e {RSP_IDLE, RSP_ACK, RSP_DATA, RSP_ERR}
  - field position localparams: OP_MSB/LSB, ADDR_MSB/LSB, WDATA_W=48
- Sub-module auto_req_fifo: synchronous FIFO, DEPTH x 64.
  - Ports: push, pop, full, empty, head data.
  - Asynchronous active-low reset.
  - Pointers wrap with an extra bit for full/empty detection.

Test Plan:
- Reset, then WRITE addr 3 wdata 48'hABCD followed by READ addr 3 -> ACK with rsp_data=3, then DATA with rsp_data=64'h0000_0000_0000_ABCD. Two req_credit pulses, each coincident with its response.
- Five back-to-back requests with DEPTH=4 and no pops possible (rsp credits held at 0 by a prior burst) -> fifth beat dropped, ovf_err=1. The remaining four responses drain after credits are returned.
- Four READs with RSP_CREDITS=4 and no rsp_credit returns -> four DATA beats, rsp_credits_avail=0. The fifth stalls until a single rsp_credit pulse, then issues 2 cycles later.
- NOP with rsp_credits_avail=0 -> req_credit pulse, rsp_cmd stays 0, counter stays 0.
- op=11 with req_dat=64'hC123_4567_89AB_CDEF -> ERR with identical rsp_data. An rsp_credit pulse while at 4 -> credit_err=1, count stays 4.
- rst_n asserted low mid-stream with 3 queued requests -> all outputs take reset values immediately. After release, READ addr 3 returns 0.

Source files
------------

// File: rtl/auto_rsp_pkg.sv
// Shared types and request field positions for the auto_intf response engine.
package auto_rsp_pkg;

    typedef enum logic [1:0] {OP_NOP, OP_WR, OP_RD, OP_BAD} op_e;
    typedef enum logic [1:0] {RSP_IDLE, RSP_ACK, RSP_DATA, RSP_ERR} rsp_cmd_e;

    localparam int DAT_W    = 64;
    localparam int OP_MSB   = 63;
    localparam int OP_LSB   = 62;
    localparam int ADDR_MSB = 59;
    localparam int ADDR_LSB = 56;
    localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
    localparam int WDATA_W  = 48;

endpackage

// File: rtl/auto_req_fifo.sv
// Request FIFO: DEPTH x W, pointers carry an extra wrap bit so full and empty differ.
module auto_req_fifo
    import auto_rsp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DAT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/auto_rsp_engine.sv
// Request consumer / response producer for auto_intf: in-order execution against
// a 48-bit register file, response beats gated by downstream credits.
module auto_rsp_engine
    import auto_rsp_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int RSP_CREDITS = 4,
    parameter int NREGS       = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_val,
    input  logic [DAT_W-1:0]                   req_dat,
    output logic                               req_credit,
    output logic [1:0]                         rsp_cmd,
    output logic [DAT_W-1:0]                   rsp_data,
    input  logic                               rsp_credit,
    output logic                               ovf_err,
    output logic                               credit_err,
    output logic [$clog2(RSP_CREDITS+1)-1:0]   rsp_credits_avail
);

    localparam int CW = $clog2(RSP_CREDITS + 1);

    logic              fifo_full, fifo_empty, push, pop;
    logic [DAT_W-1:0]  head;
    op_e               head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [WDATA_W-1:0] head_wdata;
    logic              need_cred;

    logic [CW-1:0]      credits_q, credits_d;
    logic [WDATA_W-1:0] regs_q [NREGS];
    logic [WDATA_W-1:0] regs_d [NREGS];

    // Stage 1 captures the executed result at the pop edge; stage 2 drives the ports.
    logic              s1_vld_q, s1_vld_d;
    rsp_cmd_e          s1_cmd_q, s1_cmd_d;
    logic [DAT_W-1:0]  s1_data_q, s1_data_d;
    rsp_cmd_e          rsp_cmd_q, rsp_cmd_d;
    logic [DAT_W-1:0]  rsp_data_q, rsp_data_d;
    logic              req_credit_q, req_credit_d;
    logic              ovf_q, ovf_d, cerr_q, cerr_d;

    auto_req_fifo #(.DEPTH(DEPTH), .W(DAT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (req_dat),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign head_op    = op_e'(head[OP_MSB:OP_LSB]);
    assign head_addr  = head[ADDR_MSB:ADDR_LSB];
    assign head_wdata = head[WDATA_W-1:0];
    assign need_cred  = (head_op != OP_NOP);

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign pop  = !fifo_empty && (!need_cred || (credits_q != '0));
    assign push = req_val && (!fifo_full || pop);

    always_comb begin
        ovf_d     = ovf_q | (req_val && fifo_full && !pop);
        cerr_d    = cerr_q;
        credits_d = credits_q;
        if (rsp_credit && !(pop && need_cred)) begin
            if (credits_q == CW'(RSP_CREDITS)) cerr_d    = 1'b1;
            else                               credits_d = credits_q + 1'b1;
        end else if (!rsp_credit && pop && need_cred) begin
            credits_d = credits_q - 1'b1;
        end
    end

    always_comb begin
        regs_d    = regs_q;
        s1_vld_d  = pop;
        s1_cmd_d  = RSP_IDLE;
        s1_data_d = '0;
        if (pop) begin
            case (head_op)
                OP_WR: begin
                    regs_d[head_addr] = head_wdata;
                    s1_cmd_d  = RSP_ACK;
                    s1_data_d = {{(DAT_W-ADDR_W){1'b0}}, head_addr};
                end
                OP_RD: begin
                    s1_cmd_d  = RSP_DATA;
                    s1_data_d = {{(DAT_W-WDATA_W){1'b0}}, regs_q[head_addr]};
                end
                OP_BAD: begin
                    s1_cmd_d  = RSP_ERR;
                    s1_data_d = head;
                end
                default: ;
            endcase
        end
        rsp_cmd_d    = s1_cmd_q;
        rsp_data_d   = s1_data_q;
        req_credit_d = s1_vld_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q    <= CW'(RSP_CREDITS);
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            s1_vld_q     <= 1'b0;
            s1_cmd_q     <= RSP_IDLE;
            s1_data_q    <= '0;
            rsp_cmd_q    <= RSP_IDLE;
            rsp_data_q   <= '0;
            req_credit_q <= 1'b0;
            ovf_q        <= 1'b0;
            cerr_q       <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            regs_q       <= regs_d;
            s1_vld_q     <= s1_vld_d;
            s1_cmd_q     <= s1_cmd_d;
            s1_data_q    <= s1_data_d;
            rsp_cmd_q    <= rsp_cmd_d;
            rsp_data_q   <= rsp_data_d;
            req_credit_q <= req_credit_d;
            ovf_q        <= ovf_d;
            cerr_q       <= cerr_d;
        end
    end

    assign rsp_cmd           = rsp_cmd_q;
    assign rsp_data          = rsp_data_q;
    assign req_credit        = req_credit_q;
    assign ovf_err           = ovf_q;
    assign credit_err        = cerr_q;
    assign rsp_credits_avail = credits_q;

endmodule

// File: tb/tb_auto_rsp_engine.sv
// Scoreboard bench for auto_rsp_engine: expected responses queued at issue time
// from an in-order register model, compared by a monitor on every req_credit.
module tb_auto_rsp_engine;
    import auto_rsp_pkg::*;

    localparam int DEPTH = 4, RSP_CREDITS = 4, NREGS = 16;
    localparam int CW = $clog2(RSP_CREDITS + 1);

    logic          clk = 1'b0, rst_n = 1'b0, req_val = 1'b0, rsp_credit = 1'b0;
    logic [63:0]   req_dat = '0;
    logic          req_credit, ovf_err, credit_err;
    logic [1:0]    rsp_cmd;
    logic [63:0]   rsp_data;
    logic [CW-1:0] rsp_credits_avail;

    auto_rsp_engine #(.DEPTH(DEPTH), .RSP_CREDITS(RSP_CREDITS), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_dat(req_dat),
        .req_credit(req_credit), .rsp_cmd(rsp_cmd), .rsp_data(rsp_data),
        .rsp_credit(rsp_credit), .ovf_err(ovf_err), .credit_err(credit_err),
        .rsp_credits_avail(rsp_credits_avail)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] cmd; logic [63:0] data; } exp_t;
    exp_t        expq[$];
    logic [47:0] mreg [NREGS];
    int checks = 0, failures = 0;
    int sent = 0, rcvd = 0, beats = 0, returned = 0;
    bit sdone;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] op, input logic [3:0] a, input logic [47:0] w);
        return {op, 2'b00, a, 8'h00, w};
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_credit) begin
                    rcvd++;
                    if (rsp_cmd != 2'd0) beats++;
                    if (expq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_rsp: got cmd=%0d data=%h expected none", rsp_cmd, rsp_data);
                    end else begin
                        e = expq.pop_front();
                        chk("rsp_cmd", {62'd0, rsp_cmd}, {62'd0, e.cmd});
                        chk("rsp_data", rsp_data, e.data);
                    end
                end else if (rsp_cmd != 2'd0) begin
                    checks++; failures++;
                    $display("FAIL beat_without_credit: got cmd=%0d with req_credit=0 expected req_credit=1", rsp_cmd);
                end
            end
        end
    endtask

    // Issues one request beat; drop=1 forces a beat the engine must discard.
    task automatic send(input logic [63:0] d, input bit drop = 1'b0);
        int t = 0;
        logic [3:0] a;
        if (!drop) begin
            while (DEPTH - sent + rcvd <= 0 && t < 1000) begin
                @(posedge clk); #1; t++;
            end
            if (t >= 1000) begin
                checks++; failures++;
                $display("FAIL send_timeout: got no request credit expected one within 1000 cycles");
                return;
            end
        end
        req_val = 1'b1;
        req_dat = d;
        if (!drop) begin
            sent++;
            a = d[59:56];
            case (d[63:62])
                2'd0: expq.push_back('{2'd0, 64'd0});
                2'd1: begin mreg[a] = d[47:0]; expq.push_back('{2'd1, {60'd0, a}}); end
                2'd2: expq.push_back('{2'd2, {16'd0, mreg[a]}});
                default: expq.push_back('{2'd3, d});
            endcase
        end
        @(posedge clk); #1;
        req_val = 1'b0;
    endtask

    task automatic pulse_credit();
        rsp_credit = 1'b1;
        @(posedge clk); #1;
        rsp_credit = 1'b0;
    endtask

    // Waits for all expected responses; with ret=1 returns every response credit.
    task automatic drain(input bit ret);
        int t = 0;
        while ((expq.size() != 0 || (ret && beats != returned)) && t < 2000) begin
            @(posedge clk); #1;
            rsp_credit = 1'b0;
            if (ret && beats > returned && $urandom_range(0, 1) == 1) begin
                rsp_credit = 1'b1;
                returned++;
            end
            t++;
        end
        @(posedge clk); #1;
        rsp_credit = 1'b0;
        if (t >= 2000) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_avail(input string nm);
        chk(nm, 64'(rsp_credits_avail), 64'(RSP_CREDITS - beats + returned));
    endtask

    // Cycles from now until the next req_credit pulse is observed.
    task automatic measure_lat(input string nm, input int exp_lat);
        int snap = rcvd, lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clk); @(negedge clk); #1;
            if (rcvd != snap) lat = k;
        end
        chk(nm, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_val = 1'b0; rsp_credit = 1'b0;
        expq.delete();
        sent = 0; rcvd = 0; beats = 0; returned = 0;
        for (int i = 0; i < NREGS; i++) mreg[i] = '0;
    endtask

    initial begin
        int snap;
        fork monitor(); join_none
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_cmd", {62'd0, rsp_cmd}, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_req_credit", {63'd0, req_credit}, 64'd0);
        chk("rst_ovf", {63'd0, ovf_err}, 64'd0);
        chk("rst_cerr", {63'd0, credit_err}, 64'd0);
        chk("rst_avail", 64'(rsp_credits_avail), 64'(RSP_CREDITS));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read, with latency measurement on the first beat.
        send(mk(2'd1, 4'd3, 48'hABCD));
        measure_lat("wr_latency", 2);
        send(mk(2'd2, 4'd3, 48'd0));
        send(mk(2'd1, 4'd5, 48'h1234_5678_9ABC));
        send(mk(2'd2, 4'd5, 48'd0));
        drain(1);
        chk_avail("avail_after_wr_rd");

        // Exhaust response credits, then stall until one returns.
        for (int i = 0; i < 4; i++) send(mk(2'd2, 4'd3, 48'd0));
        drain(0);
        chk_avail("avail_exhausted");
        send(mk(2'd2, 4'd5, 48'd0));
        snap = rcvd;
        repeat (6) @(posedge clk);
        #1;
        chk("stall_no_rsp", 64'(rcvd), 64'(snap));
        pulse_credit();
        returned++;
        measure_lat("stall_release_latency", 2);
        drain(0);
        chk_avail("avail_after_release");

        // NOP needs no response credit.
        send(mk(2'd0, 4'd7, 48'hFFFF));
        drain(0);
        chk_avail("avail_after_nop");

        // Overflow: four stalled writes fill the FIFO, the fifth is dropped.
        chk("ovf_before", {63'd0, ovf_err}, 64'd0);
        for (int i = 0; i < 4; i++) send(mk(2'd1, 4'(8 + i), 48'(32'h1000 + i)));
        send(mk(2'd1, 4'd12, 48'hDEAD), 1'b1);
        chk("ovf_set", {63'd0, ovf_err}, 64'd1);
        drain(1);
        chk_avail("avail_after_ovf_drain");
        send(mk(2'd2, 4'd12, 48'd0));
        drain(1);

        // Bad op echo, then a credit return at saturation.
        send(64'hC123_4567_89AB_CDEF);
        drain(1);
        chk("avail_full", 64'(rsp_credits_avail), 64'(RSP_CREDITS));
        chk("cerr_before", {63'd0, credit_err}, 64'd0);
        pulse_credit();
        @(posedge clk); #1;
        chk("cerr_set", {63'd0, credit_err}, 64'd1);
        chk("avail_saturated", 64'(rsp_credits_avail), 64'(RSP_CREDITS));

        // Random traffic with randomly delayed credit returns.
        sdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    send(mk(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                            {16'($urandom), 32'($urandom)}));
                end
                sdone = 1'b1;
            end
            begin
                for (int t = 0; t < 20000 && !sdone; t++) begin
                    @(posedge clk); #1;
                    rsp_credit = 1'b0;
                    if (beats > returned && $urandom_range(0, 2) == 0) begin
                        rsp_credit = 1'b1;
                        returned++;
                    end
                end
                rsp_credit = 1'b0;
            end
        join
        drain(1);
        chk_avail("avail_after_random");
        chk("ovf_sticky", {63'd0, ovf_err}, 64'd1);

        // Reset mid-stream with three requests queued behind exhausted credits.
        send(mk(2'd1, 4'd3, 48'h1234));
        for (int i = 0; i < 6; i++) send(mk(2'd2, 4'd3, 48'd0));
        repeat (4) @(posedge clk);
        #3;
        do_reset();
        #1;
        chk("midrst_rsp_cmd", {62'd0, rsp_cmd}, 64'd0);
        chk("midrst_req_credit", {63'd0, req_credit}, 64'd0);
        chk("midrst_ovf", {63'd0, ovf_err}, 64'd0);
        chk("midrst_cerr", {63'd0, credit_err}, 64'd0);
        chk("midrst_avail", 64'(rsp_credits_avail), 64'(RSP_CREDITS));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(mk(2'd2, 4'd3, 48'd0));
        drain(1);
        chk("post_rst_queue_empty", 64'(expq.size()), 64'd0);
        chk_avail("avail_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
